// File: rtl/ram_pipe_if.sv
// Request/response and clear-control bundle for ram_pipe.
// The master side (load/store unit) drives requests; the slave side is the memory.
interface ram_pipe_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH/8-1:0]   req_wstrb;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_err;
    logic                      clr_start;
    logic                      clr_busy;

    modport master (
        output req_valid, req_we, req_addr, req_wstrb, req_wdata, clr_start,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, clr_busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wstrb, req_wdata, clr_start,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, clr_busy
    );
endinterface

// File: rtl/ram_pipe.sv
// Byte-strobed single-port data RAM with a READ_LATENCY-deep response pipeline,
// address-error reporting and a one-word-per-cycle hardware clear engine.
module ram_pipe #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned MEM_SIZE     = 128,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    ram_pipe_if.slave   bus
);
    localparam int unsigned Bytes = DATA_WIDTH / 8;
    localparam int unsigned Words = MEM_SIZE / Bytes;
    localparam int unsigned OffW  = $clog2(Bytes);
    localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     clr_idx_q, clr_idx_d;

    logic [DATA_WIDTH-1:0] mem_q [Words];

    logic [READ_LATENCY-1:0] pv_q, pv_d;
    logic [READ_LATENCY-1:0] pe_q, pe_d;
    logic [DATA_WIDTH-1:0]   pd_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   pd_d [READ_LATENCY];

    logic                  accept;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  addr_err;
    logic                  wr_ok;
    logic [IdxW-1:0]       word_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    // Full-width range compare: high address bits must not alias into the array.
    always_comb begin
        misaligned   = |(bus.req_addr & ADDR_WIDTH'(Bytes - 1));
        out_of_range = 64'(bus.req_addr) >= 64'(MEM_SIZE);
        addr_err     = misaligned | out_of_range;
        word_idx     = IdxW'(bus.req_addr >> OffW);
        rd_word      = mem_q[word_idx];
        accept       = bus.req_valid & bus.req_ready;
        wr_ok        = accept & bus.req_we & ~addr_err;
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_start) begin
                    state_d   = StClear;
                    clr_idx_d = '0;
                end
            end
            StClear: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IdxW'(Words - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Contents are deliberately not reset; the clear engine owns zeroing.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem_q[clr_idx_q] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < int'(Bytes); b++) begin
                if (bus.req_wstrb[b]) begin
                    mem_q[word_idx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Stage 0 captures the response at acceptance; data is pre-zeroed for writes/errors.
    always_comb begin
        pv_d    = '0;
        pe_d    = '0;
        pd_d[0] = '0;
        pv_d[0] = accept;
        pe_d[0] = accept & addr_err;
        if (accept && !bus.req_we && !addr_err) begin
            pd_d[0] = rd_word;
        end
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pv_d[i] = pv_q[i-1];
            pe_d[i] = pe_q[i-1];
            pd_d[i] = pd_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            pe_q <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pd_q[i] <= '0;
            end
        end else begin
            pv_q <= pv_d;
            pe_q <= pe_d;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pd_q[i] <= pd_d[i];
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.clr_busy  = (state_q == StClear);
    assign bus.rsp_valid = pv_q[READ_LATENCY-1];
    assign bus.rsp_err   = pe_q[READ_LATENCY-1];
    assign bus.rsp_rdata = pd_q[READ_LATENCY-1];

endmodule
